// File: rtl/cpu_pkg.sv
// Shared CPU encodings: opcodes, bus source bit indices, sequencer states, instruction classes.
// Used by the control sequencer, the ALU and the bus mux.
package cpu_pkg;

  localparam int OPC_W = 5;
  localparam int SRC_W = 9;

  localparam int SRC_REG    = 0;
  localparam int SRC_HI     = 1;
  localparam int SRC_LO     = 2;
  localparam int SRC_ZHI    = 3;
  localparam int SRC_ZLO    = 4;
  localparam int SRC_PC     = 5;
  localparam int SRC_MDR    = 6;
  localparam int SRC_INPORT = 7;
  localparam int SRC_C      = 8;

  localparam logic [OPC_W-1:0] OP_LD   = 5'd0,  OP_LDI  = 5'd1,  OP_ST   = 5'd2;
  localparam logic [OPC_W-1:0] OP_ADD  = 5'd3,  OP_SUB  = 5'd4,  OP_AND  = 5'd5;
  localparam logic [OPC_W-1:0] OP_OR   = 5'd6,  OP_SHR  = 5'd7,  OP_SHRA = 5'd8;
  localparam logic [OPC_W-1:0] OP_SHL  = 5'd9,  OP_ROR  = 5'd10, OP_ROL  = 5'd11;
  localparam logic [OPC_W-1:0] OP_ADDI = 5'd12, OP_ANDI = 5'd13, OP_ORI  = 5'd14;
  localparam logic [OPC_W-1:0] OP_MUL  = 5'd15, OP_DIV  = 5'd16, OP_NEG  = 5'd17;
  localparam logic [OPC_W-1:0] OP_NOT  = 5'd18, OP_BR   = 5'd19, OP_JR   = 5'd20;
  localparam logic [OPC_W-1:0] OP_JAL  = 5'd21, OP_IN   = 5'd22, OP_OUT  = 5'd23;
  localparam logic [OPC_W-1:0] OP_MFHI = 5'd24, OP_MFLO = 5'd25, OP_NOP  = 5'd26;
  localparam logic [OPC_W-1:0] OP_HALT = 5'd27;

  localparam logic [OPC_W-1:0] ALU_ADD = OP_ADD;

  localparam logic [3:0] ST_T0 = 4'd0, ST_T1 = 4'd1, ST_T2 = 4'd2, ST_T3 = 4'd3;
  localparam logic [3:0] ST_T4 = 4'd4, ST_T5 = 4'd5, ST_T6 = 4'd6, ST_T7 = 4'd7;
  localparam logic [3:0] ST_HALTED = 4'd8;

  typedef enum logic [3:0] {
    CL_ALU, CL_IMM, CL_UNARY, CL_MULDIV, CL_LD, CL_LDI, CL_ST, CL_BR,
    CL_JR, CL_JAL, CL_MFHI, CL_MFLO, CL_IN, CL_OUT, CL_NOP, CL_HALT
  } cls_e;

  typedef struct packed {
    logic [SRC_W-1:0] bus_src;
    logic gra, grb, grc, r_in, ba_out;
    logic pc_in, ir_in, mar_in, mdr_in, y_in, z_in, hi_in, lo_in, outport_in;
    logic inc_pc, mem_read, mem_write, halted;
    logic [OPC_W-1:0] alu_op;
    logic mem_gate;  // state waits on mem_ready; its load strobes fire only when ready
    logic con_gate;  // pc_in qualified by con_ff
  } ctrl_t;

  function automatic ctrl_t ctrl_idle();
    ctrl_idle = '0;
    ctrl_idle.alu_op = ALU_ADD;
  endfunction

  // Final execute step per class; the step after it returns to T0.
  function automatic logic [2:0] last_step(input cls_e c);
    case (c)
      CL_LD, CL_ST:                  last_step = 3'd7;
      CL_MULDIV:                     last_step = 3'd6;
      CL_ALU, CL_IMM, CL_LDI, CL_BR: last_step = 3'd5;
      CL_UNARY, CL_JAL:              last_step = 3'd4;
      default:                       last_step = 3'd3;
    endcase
  endfunction

endpackage

// File: rtl/opcode_class_decode.sv
// Combinational opcode-to-class map; reserved opcodes behave as NOP.
module opcode_class_decode
  import cpu_pkg::*;
(
  input  logic [OPC_W-1:0] opc_i,
  output cls_e             cls_o
);

  always_comb begin
    cls_o = CL_NOP;
    case (opc_i)
      OP_ADD, OP_SUB, OP_AND, OP_OR, OP_SHR,
      OP_SHRA, OP_SHL, OP_ROR, OP_ROL:   cls_o = CL_ALU;
      OP_ADDI, OP_ANDI, OP_ORI:          cls_o = CL_IMM;
      OP_NEG, OP_NOT:                    cls_o = CL_UNARY;
      OP_MUL, OP_DIV:                    cls_o = CL_MULDIV;
      OP_LD:                             cls_o = CL_LD;
      OP_LDI:                            cls_o = CL_LDI;
      OP_ST:                             cls_o = CL_ST;
      OP_BR:                             cls_o = CL_BR;
      OP_JR:                             cls_o = CL_JR;
      OP_JAL:                            cls_o = CL_JAL;
      OP_MFHI:                           cls_o = CL_MFHI;
      OP_MFLO:                           cls_o = CL_MFLO;
      OP_IN:                             cls_o = CL_IN;
      OP_OUT:                            cls_o = CL_OUT;
      OP_HALT:                           cls_o = CL_HALT;
      default:                           cls_o = CL_NOP;
    endcase
  end

endmodule

// File: rtl/control_sequencer.sv
// Hardwired fetch/decode/execute sequencer (T0..T7) for the single-bus datapath.
// Strobes are registered from the next state; memory-phase loads and the branch pc_in are qualified live.
module control_sequencer
  import cpu_pkg::*;
(
  input  logic             clock,
  input  logic             clear_n,
  input  logic [31:0]      ir,
  input  logic             con_ff,
  input  logic             mem_ready,
  input  logic             run,
  output logic [SRC_W-1:0] bus_src,
  output logic             gra,
  output logic             grb,
  output logic             grc,
  output logic             r_in,
  output logic             ba_out,
  output logic             pc_in,
  output logic             ir_in,
  output logic             mar_in,
  output logic             mdr_in,
  output logic             y_in,
  output logic             z_in,
  output logic             hi_in,
  output logic             lo_in,
  output logic             outport_in,
  output logic             inc_pc,
  output logic             mem_read,
  output logic             mem_write,
  output logic [OPC_W-1:0] alu_op,
  output logic             halted
);

  logic [3:0]       state_q, state_d;
  ctrl_t            ctrl_q, ctrl_d;
  cls_e             cls;
  logic [OPC_W-1:0] opc;
  logic [2:0]       last;
  logic             mem_wait;
  logic             unused_ir;

  assign opc       = ir[31:27];
  assign unused_ir = ^ir[26:0];
  assign last      = last_step(cls);
  assign mem_wait  = ctrl_q.mem_gate & ~mem_ready;

  opcode_class_decode u_dec (
    .opc_i (opc),
    .cls_o (cls)
  );

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_HALTED: if (run) state_d = ST_T0;
      ST_T0:     state_d = ST_T1;
      ST_T1:     if (!mem_wait) state_d = ST_T2;
      ST_T2:     state_d = (cls == CL_HALT) ? ST_HALTED : ST_T3;
      ST_T3, ST_T4, ST_T5, ST_T6, ST_T7: begin
        if (mem_wait)                  state_d = state_q;
        else if (state_q[2:0] == last) state_d = ST_T0;
        else                           state_d = state_q + 4'd1;
      end
      default:   state_d = ST_HALTED;
    endcase
  end

  // Control word for the state about to be entered.
  always_comb begin
    ctrl_d = ctrl_idle();
    case (state_d)
      ST_HALTED: ctrl_d.halted = 1'b1;
      ST_T0: begin
        ctrl_d.bus_src[SRC_PC] = 1'b1; ctrl_d.mar_in = 1'b1; ctrl_d.y_in = 1'b1;
        ctrl_d.inc_pc = 1'b1; ctrl_d.z_in = 1'b1;
      end
      ST_T1: begin
        ctrl_d.bus_src[SRC_ZLO] = 1'b1; ctrl_d.pc_in = 1'b1; ctrl_d.mem_read = 1'b1;
        ctrl_d.mdr_in = 1'b1; ctrl_d.mem_gate = 1'b1;
      end
      ST_T2: begin
        ctrl_d.bus_src[SRC_MDR] = 1'b1; ctrl_d.ir_in = 1'b1;
      end
      ST_T3: case (cls)
        CL_ALU, CL_IMM: begin ctrl_d.grb = 1'b1; ctrl_d.bus_src[SRC_REG] = 1'b1; ctrl_d.y_in = 1'b1; end
        CL_LD, CL_LDI, CL_ST: begin
          ctrl_d.grb = 1'b1; ctrl_d.ba_out = 1'b1; ctrl_d.bus_src[SRC_REG] = 1'b1; ctrl_d.y_in = 1'b1;
        end
        CL_UNARY: begin
          ctrl_d.grb = 1'b1; ctrl_d.bus_src[SRC_REG] = 1'b1; ctrl_d.alu_op = opc; ctrl_d.z_in = 1'b1;
        end
        CL_MULDIV: begin ctrl_d.gra = 1'b1; ctrl_d.bus_src[SRC_REG] = 1'b1; ctrl_d.y_in = 1'b1; end
        CL_BR:     begin ctrl_d.bus_src[SRC_PC] = 1'b1; ctrl_d.y_in = 1'b1; end
        CL_JR:     begin ctrl_d.gra = 1'b1; ctrl_d.bus_src[SRC_REG] = 1'b1; ctrl_d.pc_in = 1'b1; end
        CL_JAL:    begin ctrl_d.bus_src[SRC_PC] = 1'b1; ctrl_d.grb = 1'b1; ctrl_d.r_in = 1'b1; end
        CL_MFHI:   begin ctrl_d.bus_src[SRC_HI] = 1'b1; ctrl_d.gra = 1'b1; ctrl_d.r_in = 1'b1; end
        CL_MFLO:   begin ctrl_d.bus_src[SRC_LO] = 1'b1; ctrl_d.gra = 1'b1; ctrl_d.r_in = 1'b1; end
        CL_IN:     begin ctrl_d.bus_src[SRC_INPORT] = 1'b1; ctrl_d.gra = 1'b1; ctrl_d.r_in = 1'b1; end
        CL_OUT:    begin ctrl_d.gra = 1'b1; ctrl_d.bus_src[SRC_REG] = 1'b1; ctrl_d.outport_in = 1'b1; end
        default: ;
      endcase
      ST_T4: case (cls)
        CL_ALU: begin
          ctrl_d.grc = 1'b1; ctrl_d.bus_src[SRC_REG] = 1'b1; ctrl_d.alu_op = opc; ctrl_d.z_in = 1'b1;
        end
        CL_IMM:    begin ctrl_d.bus_src[SRC_C] = 1'b1; ctrl_d.alu_op = opc; ctrl_d.z_in = 1'b1; end
        CL_UNARY:  begin ctrl_d.bus_src[SRC_ZLO] = 1'b1; ctrl_d.gra = 1'b1; ctrl_d.r_in = 1'b1; end
        CL_MULDIV: begin
          ctrl_d.grb = 1'b1; ctrl_d.bus_src[SRC_REG] = 1'b1; ctrl_d.alu_op = opc; ctrl_d.z_in = 1'b1;
        end
        CL_LD, CL_LDI, CL_ST, CL_BR: begin ctrl_d.bus_src[SRC_C] = 1'b1; ctrl_d.z_in = 1'b1; end
        CL_JAL:    begin ctrl_d.gra = 1'b1; ctrl_d.bus_src[SRC_REG] = 1'b1; ctrl_d.pc_in = 1'b1; end
        default: ;
      endcase
      ST_T5: case (cls)
        CL_ALU, CL_IMM, CL_LDI: begin ctrl_d.bus_src[SRC_ZLO] = 1'b1; ctrl_d.gra = 1'b1; ctrl_d.r_in = 1'b1; end
        CL_MULDIV:   begin ctrl_d.bus_src[SRC_ZLO] = 1'b1; ctrl_d.lo_in = 1'b1; end
        CL_LD, CL_ST: begin ctrl_d.bus_src[SRC_ZLO] = 1'b1; ctrl_d.mar_in = 1'b1; end
        CL_BR: begin ctrl_d.bus_src[SRC_ZLO] = 1'b1; ctrl_d.pc_in = 1'b1; ctrl_d.con_gate = 1'b1; end
        default: ;
      endcase
      ST_T6: case (cls)
        CL_MULDIV: begin ctrl_d.bus_src[SRC_ZHI] = 1'b1; ctrl_d.hi_in = 1'b1; end
        CL_LD:     begin ctrl_d.mem_read = 1'b1; ctrl_d.mdr_in = 1'b1; ctrl_d.mem_gate = 1'b1; end
        CL_ST:     begin ctrl_d.gra = 1'b1; ctrl_d.bus_src[SRC_REG] = 1'b1; ctrl_d.mdr_in = 1'b1; end
        default: ;
      endcase
      ST_T7: case (cls)
        CL_LD: begin ctrl_d.bus_src[SRC_MDR] = 1'b1; ctrl_d.gra = 1'b1; ctrl_d.r_in = 1'b1; end
        CL_ST: begin ctrl_d.mem_write = 1'b1; ctrl_d.mem_gate = 1'b1; end
        default: ;
      endcase
      default: ;
    endcase
  end

  always_ff @(posedge clock or negedge clear_n) begin
    if (!clear_n) begin
      state_q <= ST_HALTED;
      ctrl_q  <= ctrl_idle();
    end else begin
      state_q <= state_d;
      ctrl_q  <= ctrl_d;
    end
  end

  assign bus_src    = ctrl_q.bus_src;
  assign gra        = ctrl_q.gra;
  assign grb        = ctrl_q.grb;
  assign grc        = ctrl_q.grc;
  assign r_in       = ctrl_q.r_in;
  assign ba_out     = ctrl_q.ba_out;
  assign pc_in      = ctrl_q.pc_in & (~ctrl_q.mem_gate | mem_ready) & (~ctrl_q.con_gate | con_ff);
  assign ir_in      = ctrl_q.ir_in;
  assign mar_in     = ctrl_q.mar_in;
  assign mdr_in     = ctrl_q.mdr_in & (~ctrl_q.mem_gate | mem_ready);
  assign y_in       = ctrl_q.y_in;
  assign z_in       = ctrl_q.z_in;
  assign hi_in      = ctrl_q.hi_in;
  assign lo_in      = ctrl_q.lo_in;
  assign outport_in = ctrl_q.outport_in;
  assign inc_pc     = ctrl_q.inc_pc;
  assign mem_read   = ctrl_q.mem_read;
  assign mem_write  = ctrl_q.mem_write;
  assign alu_op     = ctrl_q.alu_op;
  assign halted     = ctrl_q.halted;

  a_bus_onehot: assert property (@(posedge clock) disable iff (!clear_n) $onehot0(bus_src));

endmodule

// File: tb/tb_control_sequencer.sv
// Directed and random-opcode checks of the control sequencer's per-cycle control word.
module tb_control_sequencer;

  logic        clock = 1'b0;
  logic        clear_n, con_ff, mem_ready, run;
  logic [31:0] ir;
  logic [8:0]  bus_src;
  logic        gra, grb, grc, r_in, ba_out, pc_in, ir_in, mar_in, mdr_in, y_in, z_in;
  logic        hi_in, lo_in, outport_in, inc_pc, mem_read, mem_write, halted;
  logic [4:0]  alu_op;

  int vectors = 0;
  int miscompares = 0;

  always #5 clock = ~clock;

  control_sequencer dut (
    .clock(clock), .clear_n(clear_n), .ir(ir), .con_ff(con_ff), .mem_ready(mem_ready), .run(run),
    .bus_src(bus_src), .gra(gra), .grb(grb), .grc(grc), .r_in(r_in), .ba_out(ba_out),
    .pc_in(pc_in), .ir_in(ir_in), .mar_in(mar_in), .mdr_in(mdr_in), .y_in(y_in), .z_in(z_in),
    .hi_in(hi_in), .lo_in(lo_in), .outport_in(outport_in), .inc_pc(inc_pc),
    .mem_read(mem_read), .mem_write(mem_write), .alu_op(alu_op), .halted(halted)
  );

  // Snapshot layout: {alu_op[4:0], bus_src[8:0], 18 single-bit strobes}
  localparam logic [31:0] H = 32'h1 << 0,  MW = 32'h1 << 1,  MR = 32'h1 << 2,   INC = 32'h1 << 3;
  localparam logic [31:0] OUTP = 32'h1 << 4, LO = 32'h1 << 5, HI = 32'h1 << 6,  Z = 32'h1 << 7;
  localparam logic [31:0] Y = 32'h1 << 8,  MDRI = 32'h1 << 9, MAR = 32'h1 << 10, IRI = 32'h1 << 11;
  localparam logic [31:0] PCI = 32'h1 << 12, BA = 32'h1 << 13, RIN = 32'h1 << 14, GRC = 32'h1 << 15;
  localparam logic [31:0] GRB = 32'h1 << 16, GRA = 32'h1 << 17;
  localparam logic [31:0] B_REG = 32'h1 << 18, B_HI = 32'h1 << 19, B_LO = 32'h1 << 20;
  localparam logic [31:0] B_ZHI = 32'h1 << 21, B_ZLO = 32'h1 << 22, B_PC = 32'h1 << 23;
  localparam logic [31:0] B_MDR = 32'h1 << 24, B_INP = 32'h1 << 25, B_C = 32'h1 << 26;
  localparam logic [31:0] A_ADD = 32'd3 << 27, A_MUL = 32'd15 << 27;
  localparam logic [31:0] T0V = A_ADD | B_PC | MAR | Y | INC | Z;
  localparam logic [31:0] T1V = A_ADD | B_ZLO | PCI | MR | MDRI;
  localparam logic [31:0] T2V = A_ADD | B_MDR | IRI;

  function automatic logic [31:0] snap();
    return {alu_op, bus_src, gra, grb, grc, r_in, ba_out, pc_in, ir_in, mar_in, mdr_in,
            y_in, z_in, hi_in, lo_in, outport_in, inc_pc, mem_read, mem_write, halted};
  endfunction

  function automatic int exp_len(input logic [4:0] op);
    if (op == 5'd0 || op == 5'd2) return 8;
    if (op == 5'd1) return 6;
    if (op >= 5'd3 && op <= 5'd14) return 6;
    if (op == 5'd15 || op == 5'd16) return 7;
    if (op == 5'd17 || op == 5'd18) return 5;
    if (op == 5'd19) return 6;
    if (op == 5'd21) return 5;
    return 4;
  endfunction

  task automatic test_reset();
    clear_n = 1'b0; run = 1'b0; mem_ready = 1'b1; con_ff = 1'b0; ir = 32'd0;
    @(negedge clock);
    vectors++;
    if (snap() !== A_ADD) begin miscompares++; $display("FAIL reset_outputs got %h want %h", snap(), A_ADD); end
    clear_n = 1'b1;
    for (int i = 0; i < 2; i++) begin
      @(negedge clock);
      vectors++;
      if (snap() !== (A_ADD | H)) begin
        miscompares++; $display("FAIL reset_idle_halted %0d got %h want %h", i, snap(), A_ADD | H);
      end
    end
  endtask

  task automatic test_fetch();
    logic [31:0] want [4];
    want = '{T1V, T2V, A_ADD, T0V};
    ir = {5'd26, 27'd0};
    run = 1'b1;
    @(negedge clock);
    run = 1'b0;
    vectors++;
    if (snap() !== T0V) begin miscompares++; $display("FAIL fetch_T0 got %h want %h", snap(), T0V); end
    for (int i = 0; i < 4; i++) begin
      @(negedge clock);
      vectors++;
      if (snap() !== want[i]) begin
        miscompares++; $display("FAIL fetch_nop step %0d got %h want %h", i, snap(), want[i]);
      end
    end
  endtask

  task automatic test_fetch_wait();
    logic [31:0] want [6];
    want = '{A_ADD | B_ZLO | MR, A_ADD | B_ZLO | MR, T1V, T2V, A_ADD, T0V};
    ir = {5'd26, 27'd0};
    mem_ready = 1'b0;
    for (int i = 0; i < 6; i++) begin
      if (i == 2) begin @(posedge clock); #1; mem_ready = 1'b1; end
      @(negedge clock);
      vectors++;
      if (snap() !== want[i]) begin
        miscompares++; $display("FAIL fetch_wait step %0d got %h want %h", i, snap(), want[i]);
      end
    end
  endtask

  task automatic test_add();
    logic [31:0] want [6];
    want = '{T1V, T2V, A_ADD | B_REG | GRB | Y, A_ADD | B_REG | GRC | Z, A_ADD | B_ZLO | GRA | RIN, T0V};
    ir = {5'd3, 4'd1, 4'd2, 4'd3, 15'd0};
    run = 1'b1;
    for (int i = 0; i < 6; i++) begin
      @(negedge clock);
      vectors++;
      if (snap() !== want[i]) begin
        miscompares++; $display("FAIL add step %0d got %h want %h", i, snap(), want[i]);
      end
    end
    run = 1'b0;
  endtask

  task automatic test_ld_wait();
    logic [31:0] want [11];
    want = '{T1V, T2V, A_ADD | B_REG | GRB | BA | Y, A_ADD | B_C | Z, A_ADD | B_ZLO | MAR,
             A_ADD | MR, A_ADD | MR, A_ADD | MR, A_ADD | MR | MDRI, A_ADD | B_MDR | GRA | RIN, T0V};
    ir = {5'd0, 4'd1, 4'd0, 19'h55};
    for (int i = 0; i < 11; i++) begin
      if (i == 8) begin @(posedge clock); #1; mem_ready = 1'b1; end
      @(negedge clock);
      vectors++;
      if (snap() !== want[i]) begin
        miscompares++; $display("FAIL ld_wait step %0d got %h want %h", i, snap(), want[i]);
      end
      if (i == 4) mem_ready = 1'b0;
    end
  endtask

  task automatic test_br(input logic cond);
    logic [31:0] want [6];
    want = '{T1V, T2V, A_ADD | B_PC | Y, A_ADD | B_C | Z, A_ADD | B_ZLO | (cond ? PCI : 32'd0), T0V};
    ir = {5'd19, 4'd2, 4'd1, 19'h7};
    con_ff = cond;
    for (int i = 0; i < 6; i++) begin
      @(negedge clock);
      vectors++;
      if (snap() !== want[i]) begin
        miscompares++; $display("FAIL br con_ff=%0b step %0d got %h want %h", cond, i, snap(), want[i]);
      end
    end
    con_ff = 1'b0;
  endtask

  task automatic test_mul_clear();
    logic [31:0] want [7];
    want = '{T1V, T2V, A_ADD | B_REG | GRA | Y, A_MUL | B_REG | GRB | Z,
             A_ADD | B_ZLO | LO, A_ADD | B_ZHI | HI, T0V};
    ir = {5'd15, 4'd4, 4'd5, 19'd0};
    for (int i = 0; i < 7; i++) begin
      @(negedge clock);
      vectors++;
      if (snap() !== want[i]) begin
        miscompares++; $display("FAIL mul step %0d got %h want %h", i, snap(), want[i]);
      end
    end
    for (int i = 0; i < 4; i++) begin
      @(negedge clock);
      vectors++;
      if (snap() !== want[i]) begin
        miscompares++; $display("FAIL mul_pre_clear step %0d got %h want %h", i, snap(), want[i]);
      end
    end
    clear_n = 1'b0;
    #1;
    vectors++;
    if (snap() !== A_ADD) begin miscompares++; $display("FAIL clear_mid_T4 got %h want %h", snap(), A_ADD); end
    @(negedge clock);
    clear_n = 1'b1;
    @(negedge clock);
    vectors++;
    if (snap() !== (A_ADD | H)) begin
      miscompares++; $display("FAIL clear_then_halted got %h want %h", snap(), A_ADD | H);
    end
    run = 1'b1;
    @(negedge clock);
    run = 1'b0;
    vectors++;
    if (snap() !== T0V) begin miscompares++; $display("FAIL clear_restart_T0 got %h want %h", snap(), T0V); end
  endtask

  task automatic test_random();
    logic [4:0] op;
    int n;
    bit ok;
    for (int k = 0; k < 2000; k++) begin
      do op = 5'($urandom_range(0, 31)); while (op == 5'd27);
      ir = {op, 27'($urandom)};
      con_ff = 1'($urandom_range(0, 1));
      n = 0;
      ok = 1'b0;
      while (n < 12 && !ok) begin
        @(negedge clock);
        n++;
        vectors++;
        if (!$onehot0(bus_src)) begin
          miscompares++; $display("FAIL random_bus_onehot instr %0d got %h want at most one bit", k, bus_src);
        end
        if (snap() === T0V) ok = 1'b1;
      end
      vectors++;
      if (!ok || n != exp_len(op)) begin
        miscompares++;
        $display("FAIL random_length instr %0d op %0d got %0d cycles want %0d", k, op, n, exp_len(op));
        if (!ok) break;
      end
    end
    con_ff = 1'b0;
  endtask

  task automatic test_halt();
    logic [31:0] want [8];
    want = '{T1V, T2V, A_ADD | H, A_ADD | H, A_ADD | H, A_ADD | H, A_ADD | H, A_ADD | H};
    ir = {5'd27, 27'd0};
    for (int i = 0; i < 8; i++) begin
      @(negedge clock);
      vectors++;
      if (snap() !== want[i]) begin
        miscompares++; $display("FAIL halt step %0d got %h want %h", i, snap(), want[i]);
      end
    end
    run = 1'b1;
    @(negedge clock);
    run = 1'b0;
    vectors++;
    if (snap() !== T0V) begin miscompares++; $display("FAIL halt_resume_T0 got %h want %h", snap(), T0V); end
  endtask

  initial begin
    test_reset();
    test_fetch();
    test_fetch_wait();
    test_add();
    test_ld_wait();
    test_br(1'b0);
    test_br(1'b1);
    test_mul_clear();
    test_random();
    test_halt();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
